cache_tag_ways: RTL

- Parametrised set-associative tag/valid store for the L1 cache controller.
- Stores a tag and a valid bit per way per set.
- Performs registered hit lookup across all ways and nominates a replacement victim using a per-set round-robin pointer.
- Owns a flush sequencer that clears every valid bit after reset or on request, one set per cycle.

---
 rtl/cache_tag_ways.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cache_tag_ways.sv
// Set-associative tag/valid store with registered hit lookup, per-set
// round-robin victim pointer and a one-set-per-cycle flush walker.
module cache_tag_ways #(
  parameter int unsigned TAG_W   = 10,
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned WAYS    = 2,
  localparam int unsigned SETS   = 2 ** INDEX_W,
  localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               hit_valid,
  output logic               hit,
  output logic [WAY_W-1:0]   hit_way,
  output logic [WAY_W-1:0]   victim_way,
  input  logic               update_en,
  input  logic [INDEX_W-1:0] update_index,
  input  logic [WAY_W-1:0]   update_way,
  input  logic [TAG_W-1:0]   update_tag,
  input  logic               invalidate_en,
  input  logic [INDEX_W-1:0] invalidate_index,
  input  logic [WAY_W-1:0]   invalidate_way,
  input  logic               flush_req,
  output logic               busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  localparam logic [WAY_W:0] WAYS_L = (WAY_W + 1)'(WAYS);

  // Storage arrays carry no reset so they can map onto RAM; the walk clears them.
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [WAYS-1:0]    r_valid [SETS];
  logic [WAY_W-1:0]   r_rr    [SETS];

  logic [0:0]         r_state;
  logic [INDEX_W-1:0] r_cnt;

  logic               r_hit_valid;
  logic               r_hit;
  logic [WAY_W-1:0]   r_hit_way;
  logic [WAY_W-1:0]   r_victim_way;

  logic               w_idle;
  logic               w_lookup_ok;
  logic               w_upd_ok;
  logic               w_inv_ok;
  logic [WAY_W-1:0]   w_rr_next;
  logic [WAYS-1:0]    w_set_valid;
  logic [TAG_W-1:0]   w_set_tags [WAYS];
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic [WAY_W-1:0]   w_victim;

  // flush_req in IDLE blocks every other request in the same cycle.
  assign w_idle      = (r_state == ST_IDLE);
  assign w_lookup_ok = w_idle && !flush_req && lookup_valid;
  assign w_upd_ok    = w_idle && !flush_req && update_en &&
                       ({1'b0, update_way} < WAYS_L);
  assign w_inv_ok    = w_idle && !flush_req && invalidate_en &&
                       ({1'b0, invalidate_way} < WAYS_L);
  assign w_rr_next   = (WAYS == 1) ? '0 : update_way + 1'b1;

  // Read the looked-up set and resolve lowest hit way and victim way.
  always_comb begin
    w_set_valid = r_valid[lookup_index];
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_victim    = r_rr[lookup_index];
    for (int w = 0; w < int'(WAYS); w++) begin
      w_set_tags[w] = r_tag[lookup_index][w];
    end
    // Descending scan so the lowest-numbered way is the last to assign.
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (w_set_valid[w] && (w_set_tags[w] == lookup_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = w[WAY_W-1:0];
      end
      if (!w_set_valid[w]) begin
        w_victim = w[WAY_W-1:0];
      end
    end
  end

  // Flush walker FSM; reset forces a full walk from set 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_FLUSH;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          r_cnt <= r_cnt + 1'b1;
          if (&r_cnt) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          if (flush_req) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
          end
        end
      endcase
    end
  end

  // Storage writes: walk clears one set; invalidate is ordered after update so it wins.
  always_ff @(posedge clk) begin
    if (r_state == ST_FLUSH) begin
      r_valid[r_cnt] <= '0;
      r_rr[r_cnt]    <= '0;
    end else begin
      if (w_upd_ok) begin
        r_tag[update_index][update_way]   <= update_tag;
        r_valid[update_index][update_way] <= 1'b1;
        r_rr[update_index]                <= w_rr_next;
      end
      if (w_inv_ok) begin
        r_valid[invalidate_index][invalidate_way] <= 1'b0;
      end
    end
  end

  // Registered lookup result; fields hold when no lookup is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hit_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_way    <= '0;
      r_victim_way <= '0;
    end else begin
      r_hit_valid <= w_lookup_ok;
      if (w_lookup_ok) begin
        r_hit        <= w_hit;
        r_hit_way    <= w_hit_way;
        r_victim_way <= w_victim;
      end
    end
  end

  assign hit_valid  = r_hit_valid;
  assign hit        = r_hit;
  assign hit_way    = r_hit_way;
  assign victim_way = r_victim_way;
  assign busy       = (r_state == ST_FLUSH);

endmodule
